// File: rtl/sonar_sensor_emulator.sv
// -----------------------------------------------------------------------------
// sonar_sensor_emulator
//   Synthesizable model of an HC-SR04 ultrasonic sensor (the responder side of
//   the trigger/echo handshake). A trigger pulse of sufficient width starts a
//   measurement. After a fixed burst delay, an echo pulse is returned whose
//   width encodes the programmed distance. A hold-off period follows before
//   the next trigger is accepted.
//
// Ports
//   clock         in   1  system clock (50 MHz nominal)
//   reset         in   1  asynchronous reset, active low
//   enable        in   1  respond to triggers (only looked at while idle)
//   distancia     in   9  simulated target distance in cm, unsigned
//   trigger       in   1  trigger input, asynchronous to clock
//   echo          out  1  echo pulse, driven straight from a flop
//   ocupado       out  1  high whenever a measurement is in progress
//   erro_trigger  out  1  one-cycle pulse when a trigger was too short
//   n_medidas     out  8  completed echo pulses, wraps at 255
// -----------------------------------------------------------------------------
module sonar_sensor_emulator #(
    parameter int TRIG_MIN_CYCLES = 500,
    parameter int BURST_CYCLES    = 10000,
    parameter int CYCLES_PER_CM   = 2941,
    parameter int MAX_CM          = 400,
    parameter int TIMEOUT_CYCLES  = 1900000,
    parameter int HOLDOFF_CYCLES  = 3000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [8:0] distancia,
    input  logic       trigger,
    output logic       echo,
    output logic       ocupado,
    output logic       erro_trigger,
    output logic [7:0] n_medidas
);

    localparam int CNT_W = 22;

    localparam logic [CNT_W-1:0] TRIG_MIN   = CNT_W'(TRIG_MIN_CYCLES);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_W  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] MAX_CM_W   = CNT_W'(MAX_CM);
    localparam logic [CNT_W-1:0] CPC_W      = CNT_W'(CYCLES_PER_CM);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_BURST,
        S_ECHO,
        S_HOLDOFF
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] width_d;
    logic             trig_meta_q;
    logic             trig_s_q;
    logic             trig_s_d1_q;
    logic             echo_q;
    logic             ocupado_q;
    logic             erro_q;
    logic [7:0]       n_medidas_q;
    logic             trig_rise;
    logic             trig_fall;

    // Distance 0 or beyond range means "no object": the sensor reports the
    // maximum timeout width instead of a scaled distance.
    function automatic logic [CNT_W-1:0] echo_width(input logic [8:0] cm);
        logic [CNT_W-1:0] cm_w;
        logic [CNT_W-1:0] w;
        cm_w = CNT_W'(cm);
        if (cm_w == '0 || cm_w > MAX_CM_W) begin
            w = TIMEOUT_W;
        end else begin
            w = cm_w * CPC_W;
        end
        return w;
    endfunction

    assign width_d   = echo_width(distancia);
    assign trig_rise = trig_s_q & ~trig_s_d1_q;
    assign trig_fall = ~trig_s_q & trig_s_d1_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            width_q     <= '0;
            trig_meta_q <= 1'b0;
            trig_s_q    <= 1'b0;
            trig_s_d1_q <= 1'b0;
            echo_q      <= 1'b0;
            ocupado_q   <= 1'b0;
            erro_q      <= 1'b0;
            n_medidas_q <= '0;
        end else begin
            trig_meta_q <= trigger;
            trig_s_q    <= trig_meta_q;
            trig_s_d1_q <= trig_s_q;
            erro_q      <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    // The edge cycle is already the first high cycle of the
                    // pulse, so the width count starts at one.
                    if (trig_rise && enable) begin
                        state_q   <= S_TRIG;
                        cnt_q     <= CNT_W'(1);
                        ocupado_q <= 1'b1;
                    end
                end
                S_TRIG: begin
                    if (trig_fall) begin
                        if (cnt_q >= TRIG_MIN) begin
                            state_q <= S_BURST;
                            cnt_q   <= '0;
                            width_q <= width_d;
                        end else begin
                            state_q   <= S_IDLE;
                            ocupado_q <= 1'b0;
                            erro_q    <= 1'b1;
                        end
                    end else if (cnt_q != CNT_MAX) begin
                        // Saturate so an absurdly long trigger cannot wrap
                        // around and be mistaken for a short one.
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_BURST: begin
                    if (cnt_q == BURST_LAST) begin
                        state_q <= S_ECHO;
                        cnt_q   <= '0;
                        echo_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_ECHO: begin
                    if (cnt_q == width_q - 1'b1) begin
                        state_q     <= S_HOLDOFF;
                        cnt_q       <= '0;
                        echo_q      <= 1'b0;
                        n_medidas_q <= n_medidas_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_HOLDOFF: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_q   <= S_IDLE;
                        cnt_q     <= '0;
                        ocupado_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    cnt_q     <= '0;
                    echo_q    <= 1'b0;
                    ocupado_q <= 1'b0;
                end
            endcase
        end
    end

    assign echo         = echo_q;
    assign ocupado      = ocupado_q;
    assign erro_trigger = erro_q;
    assign n_medidas    = n_medidas_q;

endmodule

// File: tb/tb_sonar_sensor_emulator.sv
// -----------------------------------------------------------------------------
// tb_sonar_sensor_emulator
//   Scoreboard bench for the sonar sensor emulator. Stimulus pushes the echo
//   it expects (width and resulting measurement count) into a queue; a monitor
//   watches the echo line, measures each pulse and its latency, and pops and
//   compares. Timing parameters are shortened so the run stays short.
// -----------------------------------------------------------------------------
module tb_sonar_sensor_emulator;

    localparam int BURST   = 100;
    localparam int HOLDOFF = 1000;
    localparam int TIMEOUT = 5000;
    localparam int CPC     = 2941;

    typedef struct {
        int width;
        int n_after;
        bit aborted;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [8:0] distancia;
    logic       trigger;
    logic       echo;
    logic       ocupado;
    logic       erro_trigger;
    logic [7:0] n_medidas;

    exp_t q[$];
    int   n_checks    = 0;
    int   n_err       = 0;
    int   cyc         = 0;
    int   fall_cyc    = 0;
    int   err_cnt     = 0;
    int   err_run_max = 0;

    sonar_sensor_emulator #(
        .BURST_CYCLES   (BURST),
        .HOLDOFF_CYCLES (HOLDOFF),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .distancia    (distancia),
        .trigger      (trigger),
        .echo         (echo),
        .ocupado      (ocupado),
        .erro_trigger (erro_trigger),
        .n_medidas    (n_medidas)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic send_trigger(input int hi_cycles);
        @(posedge clock);
        #1 trigger = 1'b1;
        repeat (hi_cycles) @(posedge clock);
        #1 trigger = 1'b0;
        fall_cyc = cyc;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clock);
        while (ocupado !== 1'b0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(name, int'(ocupado), 0);
    endtask

    task automatic wait_echo(input string name, input logic level, input int budget);
        int n;
        n = 0;
        @(negedge clock);
        while (echo !== level && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(name, int'(echo), int'(level));
    endtask

    // Monitor: measures every echo pulse and compares it against the queue.
    initial begin : monitor
        logic prev_echo;
        logic prev_err;
        int   rise_cyc;
        int   width;
        int   err_run;
        exp_t e;
        prev_echo = 1'b0;
        prev_err  = 1'b0;
        rise_cyc  = 0;
        err_run   = 0;
        forever begin
            @(negedge clock);
            if (erro_trigger === 1'b1) begin
                err_run++;
                if (!prev_err) err_cnt++;
                if (err_run > err_run_max) err_run_max = err_run;
            end else begin
                err_run = 0;
            end
            prev_err = (erro_trigger === 1'b1);

            if (echo === 1'b1 && !prev_echo) begin
                rise_cyc = cyc;
                check_range("echo_latency", cyc - fall_cyc, BURST + 2, BURST + 4);
            end
            if (echo !== 1'b1 && prev_echo) begin
                width = cyc - rise_cyc;
                if (q.size() == 0) begin
                    check("unexpected_echo_width", width, 0);
                end else begin
                    e = q.pop_front();
                    if (e.aborted) begin
                        check_range("aborted_width", width, 1, e.width - 1);
                        check("aborted_n_medidas", int'(n_medidas), 0);
                    end else begin
                        check("echo_width", width, e.width);
                        check("n_medidas_after_echo", int'(n_medidas), e.n_after);
                    end
                end
            end
            prev_echo = (echo === 1'b1);
        end
    end

    initial begin : stimulus
        int e0;
        reset     = 1'b0;
        enable    = 1'b1;
        distancia = 9'd0;
        trigger   = 1'b0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_echo", int'(echo), 0);
        check("rst_ocupado", int'(ocupado), 0);
        check("rst_erro", int'(erro_trigger), 0);
        check("rst_n_medidas", int'(n_medidas), 0);
        reset = 1'b1;
        repeat (3) @(posedge clock);

        // Normal 10 cm measurement, minimum accepted trigger width
        distancia = 9'd10;
        q.push_back('{width: 10 * CPC, n_after: 1, aborted: 1'b0});
        send_trigger(500);
        check("busy_after_trigger", int'(ocupado), 1);
        wait_idle("idle_after_10cm", 40000);
        check("n_medidas_10cm", int'(n_medidas), 1);
        check("queue_empty_10cm", q.size(), 0);

        // Short triggers (250 and 499 cycles) are rejected
        e0 = err_cnt;
        send_trigger(250);
        wait_idle("idle_after_short", 50);
        send_trigger(499);
        wait_idle("idle_after_499", 50);
        repeat (200) @(negedge clock);
        check("short_trigger_errors", err_cnt - e0, 2);
        check("erro_pulse_width", err_run_max, 1);
        check("n_medidas_after_short", int'(n_medidas), 1);
        check("echo_low_after_short", int'(echo), 0);

        // Disabled: trigger ignored while idle
        enable = 1'b0;
        send_trigger(500);
        repeat (20) @(negedge clock);
        check("disabled_ocupado", int'(ocupado), 0);
        enable = 1'b1;
        repeat (5) @(posedge clock);

        // Out-of-range distances give the timeout width; 1 cm is the smallest
        distancia = 9'd0;
        q.push_back('{width: TIMEOUT, n_after: 2, aborted: 1'b0});
        send_trigger(500);
        wait_idle("idle_after_0cm", 10000);
        distancia = 9'd450;
        q.push_back('{width: TIMEOUT, n_after: 3, aborted: 1'b0});
        send_trigger(500);
        wait_idle("idle_after_450cm", 10000);
        distancia = 9'd1;
        q.push_back('{width: CPC, n_after: 4, aborted: 1'b0});
        send_trigger(500);
        wait_idle("idle_after_1cm", 10000);

        // Retriggers during ECHO and HOLDOFF are ignored; enable drop is ignored
        e0 = err_cnt;
        distancia = 9'd2;
        q.push_back('{width: 2 * CPC, n_after: 5, aborted: 1'b0});
        send_trigger(500);
        wait_echo("echo_rise_2cm", 1'b1, 500);
        enable = 1'b0;
        send_trigger(500);
        wait_echo("echo_fall_2cm", 1'b0, 8000);
        send_trigger(500);
        check("busy_in_holdoff", int'(ocupado), 1);
        wait_idle("idle_after_2cm", 3000);
        enable = 1'b1;
        repeat (300) @(negedge clock);
        check("n_medidas_retrigger", int'(n_medidas), 5);
        check("retrigger_no_error", err_cnt - e0, 0);
        check("queue_empty_retrigger", q.size(), 0);

        // Distance change during ECHO does not affect the pulse in flight
        distancia = 9'd4;
        q.push_back('{width: 4 * CPC, n_after: 6, aborted: 1'b0});
        send_trigger(500);
        wait_echo("echo_rise_4cm", 1'b1, 500);
        distancia = 9'd9;
        wait_idle("idle_after_4cm", 20000);
        check("n_medidas_latched", int'(n_medidas), 6);

        // Reset in the middle of ECHO drops echo at once
        distancia = 9'd4;
        q.push_back('{width: 4 * CPC, n_after: 0, aborted: 1'b1});
        send_trigger(500);
        wait_echo("echo_rise_abort", 1'b1, 500);
        repeat (100) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check("abort_echo", int'(echo), 0);
        check("abort_ocupado", int'(ocupado), 0);
        check("abort_n_medidas", int'(n_medidas), 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        check("abort_popped", q.size(), 0);

        // Recovery after reset
        distancia = 9'd1;
        q.push_back('{width: CPC, n_after: 1, aborted: 1'b0});
        send_trigger(500);
        wait_idle("idle_after_recovery", 10000);
        repeat (10) @(negedge clock);
        check("final_queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
